// File: rtl/p23_spi_target.sv
// SPI target endpoint: oversamples an external mode-0/CPOL-selectable SPI bus in the clk domain,
// receives and transmits 8-bit MSB-first frames, and exposes one RX and one TX byte on a valid/ready register port.
module p23_spi_target #(
    parameter logic       CPOL        = 1'b0,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] FILL        = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ctrl,
    input  logic        valid,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        irq,
    input  logic        sclk,
    input  logic        cen,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe
);

    typedef enum logic {ST_IDLE, ST_SEL} state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cen_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;
    logic                   r_cen_d;

    state_t      r_state;
    logic [2:0]  r_bit_cnt;
    logic [6:0]  r_shift_rx;
    logic [7:0]  r_shift_tx;
    logic [7:0]  r_rx_data;
    logic [7:0]  r_tx_hold;
    logic        r_rx_valid;
    logic        r_overrun;
    logic        r_underrun;
    logic        r_tx_full;
    logic        r_miso;
    logic        r_miso_oe;
    logic        r_ready;
    logic [31:0] r_rdata;

    logic       w_sclk_s;
    logic       w_cen_s;
    logic       w_mosi_s;
    logic       w_lead;
    logic       w_trail;
    logic       w_cen_fall;
    logic       w_cen_rise;
    logic       w_acc;
    logic       w_data_rd;
    logic       w_data_wr;
    logic       w_stat_wr;
    logic       w_tx_load;
    logic       w_frame_done;
    logic [7:0] w_rx_next;
    logic       w_unused;

    assign w_sclk_s   = r_sclk_sync[SYNC_STAGES-1];
    assign w_cen_s    = r_cen_sync[SYNC_STAGES-1];
    assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
    assign w_lead     = (w_sclk_s != CPOL) && (r_sclk_d == CPOL);
    assign w_trail    = (w_sclk_s == CPOL) && (r_sclk_d != CPOL);
    assign w_cen_fall = !w_cen_s && r_cen_d;
    assign w_cen_rise = w_cen_s && !r_cen_d;

    assign w_acc     = valid && !r_ready;
    assign w_data_rd = w_acc && ctrl && !wstrb[0];
    assign w_data_wr = w_acc && ctrl && wstrb[0];
    assign w_stat_wr = w_acc && !ctrl && wstrb[0];

    assign w_rx_next    = {r_shift_rx, w_mosi_s};
    assign w_frame_done = (r_state == ST_SEL) && !w_cen_rise && w_lead && (r_bit_cnt == 3'd7);
    // A new TX byte is needed on selection and on the trailing edge that closes each frame.
    assign w_tx_load    = ((r_state == ST_IDLE) && w_cen_fall) ||
                          ((r_state == ST_SEL) && !w_cen_rise && w_trail && (r_bit_cnt == 3'd0));

    assign w_unused = &{1'b0, wstrb[3:1], wdata[31:8]};

    assign rdata   = r_rdata;
    assign ready   = r_ready;
    assign irq     = r_rx_valid | r_overrun;
    assign miso    = r_miso;
    assign miso_oe = r_miso_oe;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sclk_sync <= {SYNC_STAGES{CPOL}};
            r_cen_sync  <= {SYNC_STAGES{1'b1}};
            r_mosi_sync <= '0;
            r_sclk_d    <= CPOL;
            r_cen_d     <= 1'b1;
            r_state     <= ST_IDLE;
            r_bit_cnt   <= 3'd0;
            r_shift_rx  <= '0;
            r_shift_tx  <= '0;
            r_rx_data   <= '0;
            r_tx_hold   <= FILL;
            r_rx_valid  <= 1'b0;
            r_overrun   <= 1'b0;
            r_underrun  <= 1'b0;
            r_tx_full   <= 1'b0;
            r_miso      <= 1'b0;
            r_miso_oe   <= 1'b0;
            r_ready     <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_cen_sync  <= {r_cen_sync[SYNC_STAGES-2:0], cen};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_sclk_d    <= w_sclk_s;
            r_cen_d     <= w_cen_s;
            r_miso      <= r_shift_tx[7];
            r_miso_oe   <= (r_state == ST_SEL);
            r_ready     <= w_acc;

            if (w_acc) begin
                r_rdata <= ctrl ? {24'b0, r_rx_data}
                                : {27'b0, ~w_cen_s, r_underrun, r_overrun, r_tx_full, r_rx_valid};
            end

            // NOTE: bus clears are written first so that flag-setting events further down,
            // being later non-blocking assignments to the same register, take priority.
            if (w_data_rd) r_rx_valid <= 1'b0;
            if (w_stat_wr && wdata[2]) r_overrun <= 1'b0;
            if (w_stat_wr && wdata[3]) r_underrun <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_cen_fall) begin
                        r_bit_cnt <= 3'd0;
                        r_state   <= ST_SEL;
                    end
                end
                ST_SEL: begin
                    if (w_cen_rise) begin
                        r_bit_cnt <= 3'd0;
                        r_state   <= ST_IDLE;
                    end else begin
                        if (w_lead) begin
                            r_shift_rx <= w_rx_next[6:0];
                            r_bit_cnt  <= r_bit_cnt + 3'd1;
                        end
                        if (w_trail && (r_bit_cnt != 3'd0)) begin
                            r_shift_tx <= {r_shift_tx[6:0], 1'b0};
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_frame_done) begin
                r_rx_data  <= w_rx_next;
                r_rx_valid <= 1'b1;
                if (r_rx_valid && !w_data_rd) r_overrun <= 1'b1;
            end

            if (w_tx_load) begin
                if (r_tx_full) begin
                    r_shift_tx <= r_tx_hold;
                    r_tx_full  <= 1'b0;
                end else begin
                    r_shift_tx <= FILL;
                    r_underrun <= 1'b1;
                end
            end

            if (w_data_wr) begin
                r_tx_hold <= wdata[7:0];
                r_tx_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_p23_spi_target.sv
// Directed bench for p23_spi_target: a CPOL=0 and a CPOL=1 instance driven by a simple bit-banged SPI master.
`timescale 1ns/1ps
module tb_p23_spi_target;

    logic        clk = 1'b0;
    logic        reset;
    logic        ctrl;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        mosi;

    logic        valid0, sclk0, cen0;
    logic [31:0] rdata0;
    logic        ready0, irq0, miso0, miso_oe0;

    logic        valid1, sclk1, cen1;
    logic [31:0] rdata1;
    logic        ready1, irq1, miso1, miso_oe1;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] rd;
    logic [7:0]  got;

    always #5 clk = ~clk;

    p23_spi_target #(.CPOL(1'b0), .SYNC_STAGES(2), .FILL(8'hFF)) dut0 (
        .clk(clk), .reset(reset), .ctrl(ctrl), .valid(valid0), .wstrb(wstrb), .wdata(wdata),
        .rdata(rdata0), .ready(ready0), .irq(irq0), .sclk(sclk0), .cen(cen0), .mosi(mosi),
        .miso(miso0), .miso_oe(miso_oe0)
    );

    p23_spi_target #(.CPOL(1'b1), .SYNC_STAGES(2), .FILL(8'hFF)) dut1 (
        .clk(clk), .reset(reset), .ctrl(ctrl), .valid(valid1), .wstrb(wstrb), .wdata(wdata),
        .rdata(rdata1), .ready(ready1), .irq(irq1), .sclk(sclk1), .cen(cen1), .mosi(mosi),
        .miso(miso1), .miso_oe(miso_oe1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One bus access; every access also checks that ready arrived within the budget.
    task automatic bus(input int dut, input logic c, input logic wr, input logic [31:0] wd,
                       output logic [31:0] rdv);
        logic seen;
        seen  = 1'b0;
        rdv   = '0;
        ctrl  = c;
        wstrb = {3'b000, wr};
        wdata = wd;
        if (dut == 0) valid0 = 1'b1; else valid1 = 1'b1;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (dut == 0 && ready0) begin seen = 1'b1; rdv = rdata0; end
            if (dut == 1 && ready1) begin seen = 1'b1; rdv = rdata1; end
        end
        valid0 = 1'b0;
        valid1 = 1'b0;
        wstrb  = '0;
        check("bus_ready", {31'b0, seen}, 32'd1);
        wait_clk(1);
    endtask

    task automatic set_lines(input int dut, input logic s, input logic c);
        if (dut == 0) begin sclk0 = s; cen0 = c; end
        else          begin sclk1 = s; cen1 = c; end
    endtask

    // Mode-0 style master (CPHA=0); sclk half period 4 clk. Partial frames leave cen low.
    task automatic spi(input int dut, input logic [7:0] tx, input int nbits, output logic [7:0] rxb);
        logic cp;
        cp  = (dut == 0) ? 1'b0 : 1'b1;
        rxb = '0;
        set_lines(dut, cp, 1'b0);
        wait_clk(6);
        for (int i = 7; i >= 8 - nbits; i--) begin
            mosi = tx[i];
            wait_clk(4);
            set_lines(dut, ~cp, 1'b0);
            wait_clk(3);
            rxb = {rxb[6:0], (dut == 0) ? miso0 : miso1};
            wait_clk(1);
            set_lines(dut, cp, 1'b0);
        end
        if (nbits == 8) begin
            wait_clk(4);
            set_lines(dut, cp, 1'b1);
            wait_clk(6);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; ctrl = 1'b0; wstrb = '0; wdata = '0; mosi = 1'b0;
        valid0 = 1'b0; sclk0 = 1'b0; cen0 = 1'b1;
        valid1 = 1'b0; sclk1 = 1'b1; cen1 = 1'b1;
        wait_clk(4);
        reset = 1'b0;
        wait_clk(2);

        check("rst_ready", {31'b0, ready0}, 32'd0);
        check("rst_rdata", rdata0, 32'd0);
        check("rst_irq", {31'b0, irq0}, 32'd0);
        check("rst_miso", {30'b0, miso0, miso_oe0}, 32'd0);
        bus(0, 1'b0, 1'b0, 32'd0, rd);
        check("rst_status", rd, 32'h00);

        // Basic exchange: TX 0xA5 while receiving 0x3C.
        bus(0, 1'b1, 1'b1, 32'hA5, rd);
        bus(0, 1'b0, 1'b0, 32'd0, rd);
        check("txfull_status", rd, 32'h02);
        spi(0, 8'h3C, 8, got);
        check("miso_a5", {24'b0, got}, 32'hA5);
        check("irq_after_rx", {31'b0, irq0}, 32'd1);
        bus(0, 1'b0, 1'b0, 32'd0, rd);
        check("status_rx", rd, 32'h09);
        bus(0, 1'b1, 1'b0, 32'd0, rd);
        check("rx_3c", rd, 32'h3C);
        check("irq_cleared", {31'b0, irq0}, 32'd0);
        bus(0, 1'b0, 1'b1, 32'h8, rd);

        // Back-to-back frames without a read, TX empty.
        spi(0, 8'h11, 8, got);
        check("miso_fill", {24'b0, got}, 32'hFF);
        spi(0, 8'h22, 8, got);
        bus(0, 1'b0, 1'b0, 32'd0, rd);
        check("status_overrun", rd, 32'h0D);
        bus(0, 1'b1, 1'b0, 32'd0, rd);
        check("rx_22", rd, 32'h22);
        bus(0, 1'b0, 1'b1, 32'h4, rd);
        bus(0, 1'b0, 1'b0, 32'd0, rd);
        check("w1c_overrun", rd, 32'h08);
        bus(0, 1'b0, 1'b1, 32'h8, rd);
        bus(0, 1'b0, 1'b0, 32'd0, rd);
        check("w1c_underrun", rd, 32'h00);

        // Aborted frame after 4 bits, then a full 0x81.
        spi(0, 8'hF0, 4, got);
        wait_clk(4);
        cen0 = 1'b1;
        wait_clk(6);
        bus(0, 1'b0, 1'b0, 32'd0, rd);
        check("abort_status", rd, 32'h08);
        spi(0, 8'h81, 8, got);
        bus(0, 1'b0, 1'b0, 32'd0, rd);
        check("after_abort_status", rd, 32'h09);
        bus(0, 1'b1, 1'b0, 32'd0, rd);
        check("rx_81", rd, 32'h81);
        bus(0, 1'b0, 1'b1, 32'h8, rd);

        // Reset in the middle of a frame with flags pending.
        spi(0, 8'h42, 8, got);
        check("irq_pending", {31'b0, irq0}, 32'd1);
        spi(0, 8'hF0, 3, got);
        check("oe_selected", {31'b0, miso_oe0}, 32'd1);
        reset = 1'b1;
        wait_clk(2);
        check("midrst_oe", {31'b0, miso_oe0}, 32'd0);
        check("midrst_irq", {31'b0, irq0}, 32'd0);
        cen0 = 1'b1;
        wait_clk(4);
        reset = 1'b0;
        wait_clk(2);
        bus(0, 1'b0, 1'b0, 32'd0, rd);
        check("midrst_status", rd, 32'h00);
        bus(0, 1'b1, 1'b1, 32'hC3, rd);
        spi(0, 8'h96, 8, got);
        check("miso_c3", {24'b0, got}, 32'hC3);
        bus(0, 1'b0, 1'b0, 32'd0, rd);
        check("post_rst_status", rd, 32'h09);
        bus(0, 1'b1, 1'b0, 32'd0, rd);
        check("rx_96", rd, 32'h96);

        // CPOL=1 instance.
        bus(1, 1'b1, 1'b1, 32'hE7, rd);
        spi(1, 8'h5A, 8, got);
        check("cpol1_miso", {24'b0, got}, 32'hE7);
        check("cpol1_irq", {31'b0, irq1}, 32'd1);
        bus(1, 1'b1, 1'b0, 32'd0, rd);
        check("cpol1_rx", rd, 32'h5A);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
